// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Receives a framed program image over an 8N1 UART line and writes it
//   word-by-word into instruction memory, holding the core in reset until
//   a frame with a good checksum has been loaded.
//   Frame: 0xA5, N (0 = 2^ADDR_WIDTH words), 4*N payload bytes (LE words),
//   XOR checksum of all payload bytes.
// Ports:
//   clk          system clock (rising edge)
//   ck_rst       asynchronous active-high reset
//   rx_i         UART receive line (asynchronous, idles high)
//   instr_we_o   one-cycle instruction-memory write strobe
//   instr_addr_o word address of the write (held until the next write)
//   instr_data_o write data (held until the next write)
//   core_reset_o high holds the core in reset
//   load_done_o  high after a successful load
//   load_error_o high after a failed frame, until the next sync byte
module instr_mem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  ck_rst,
  input  logic                  rx_i,
  output logic                  instr_we_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic [31:0]           instr_data_o,
  output logic                  core_reset_o,
  output logic                  load_done_o,
  output logic                  load_error_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Word counter must hold both any count byte and 2^ADDR_WIDTH.
  localparam int WC_W  = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_IDLE, LD_COUNT, LD_DATA, LD_CHECK, LD_DONE
  } ld_state_t;

  // ---------------- UART receiver ----------------
  rx_state_t        r_rx_state;
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic [7:0]       r_byte;
  logic             r_frame_err;

  always_ff @(posedge clk or posedge ck_rst) begin
    if (ck_rst) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_meta    <= rx_i;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_bit_cnt  <= HALF_BIT;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_bit_cnt == '0) begin
            // Start bit must still be low at mid-bit, otherwise it was a glitch.
            if (!r_rx_sync) begin
              r_bit_cnt  <= FULL_BIT;
              r_bit_idx  <= '0;
              r_rx_state <= RX_DATA;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (r_bit_cnt == '0) begin
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt <= FULL_BIT;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            else                   r_bit_idx  <= r_bit_idx + 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (r_bit_cnt == '0) begin
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_shift;
              r_rx_state   <= RX_IDLE;
            end else begin
              r_frame_err  <= 1'b1;
              r_rx_state   <= RX_WAIT_HIGH;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rx_sync) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Loader FSM ----------------
  ld_state_t             r_ld_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [23:0]           r_asm;
  logic [1:0]            r_lane;
  logic [7:0]            r_csum;
  logic [WC_W-1:0]       r_words_left;

  always_ff @(posedge clk or posedge ck_rst) begin
    if (ck_rst) begin
      r_ld_state   <= LD_IDLE;
      instr_we_o   <= 1'b0;
      instr_addr_o <= '0;
      instr_data_o <= '0;
      core_reset_o <= 1'b1;
      load_done_o  <= 1'b0;
      load_error_o <= 1'b0;
      r_addr       <= '0;
      r_asm        <= '0;
      r_lane       <= '0;
      r_csum       <= '0;
      r_words_left <= '0;
    end else begin
      instr_we_o <= 1'b0;
      if (r_frame_err && (r_ld_state == LD_COUNT || r_ld_state == LD_DATA ||
                          r_ld_state == LD_CHECK)) begin
        load_error_o <= 1'b1;
        r_ld_state   <= LD_IDLE;
      end else if (r_byte_valid) begin
        case (r_ld_state)
          LD_IDLE, LD_DONE: begin
            if (r_byte == 8'hA5) begin
              load_error_o <= 1'b0;
              load_done_o  <= 1'b0;
              core_reset_o <= 1'b1;
              r_ld_state   <= LD_COUNT;
            end
          end
          LD_COUNT: begin
            r_words_left <= (r_byte == 8'h00) ? (WC_W'(1) << ADDR_WIDTH)
                                              : WC_W'(r_byte);
            r_addr       <= '0;
            r_csum       <= '0;
            r_lane       <= '0;
            r_ld_state   <= LD_DATA;
          end
          LD_DATA: begin
            r_csum <= r_csum ^ r_byte;
            r_lane <= r_lane + 1'b1;
            case (r_lane)
              2'd0: r_asm[7:0]   <= r_byte;
              2'd1: r_asm[15:8]  <= r_byte;
              2'd2: r_asm[23:16] <= r_byte;
              default: begin
                instr_we_o   <= 1'b1;
                instr_addr_o <= r_addr;
                instr_data_o <= {r_byte, r_asm};
                r_addr       <= r_addr + 1'b1;
                r_words_left <= r_words_left - 1'b1;
                if (r_words_left == WC_W'(1)) r_ld_state <= LD_CHECK;
              end
            endcase
          end
          LD_CHECK: begin
            if (r_byte == r_csum) begin
              load_done_o  <= 1'b1;
              core_reset_o <= 1'b0;
              r_ld_state   <= LD_DONE;
            end else begin
              load_error_o <= 1'b1;
              r_ld_state   <= LD_IDLE;
            end
          end
          default: r_ld_state <= LD_IDLE;
        endcase
      end
    end
  end

endmodule
